// File: rtl/wb_pkg.sv
// Shared constants and types for the RV32I writeback stage.
// Only wb_stage uses the optional WB_PERF_EN build macro; this package does not.
package wb_pkg;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        IDLE,
        WAIT_LD
    } wb_state_e;

    // Everything needed to finish a load once the memory answers.
    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } ld_ctx_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/half from the raw
// memory word and sign- or zero-extends it to XLEN.
module wb_stage_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value
);

    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;

    assign byte_sh = word >> {off, 3'b000};
    assign half_sh = word >> {off[1], 4'b0000};

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        value = word;
        case (funct3)
            FUNCT3_LB:  value = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
            FUNCT3_LBU: value = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
            FUNCT3_LH:  value = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
            FUNCT3_LHU: value = {{(XLEN-16){1'b0}}, half_sh[15:0]};
            default:    value = word;  // LW and unknown encodings
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: FSM that waits on variable-latency loads and registers the
// register-file write port. Optional counters enabled by defining WB_PERF_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32
`ifdef WB_PERF_EN
    ,parameter int PERF_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s3_valid,
    input  logic [31:0]     s3_inst,
    input  logic [XLEN-1:0] s3_alu,
    input  logic [XLEN-1:0] s3_pc4,
    input  logic [1:0]      s3_wbsel,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
`ifdef WB_PERF_EN
    ,output logic [PERF_W-1:0] perf_retired
    ,output logic [PERF_W-1:0] perf_ldwait
`endif
);

    wb_state_e state_q, state_d;
    ld_ctx_t   ctx_q, cur_ctx;

    logic [6:0] opcode;
    logic       is_load, is_direct, no_write_op;
    logic       stall, we_d, retire;
    logic [4:0] waddr_d;
    logic [XLEN-1:0] wdata_d, aligned;
    logic       unused_inst;

    assign opcode      = s3_inst[6:0];
    assign unused_inst = ^s3_inst[31:15];
    assign no_write_op = (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign is_load     = s3_valid && (s3_wbsel == WB_MEM) && (opcode == OP_LOAD);
    assign is_direct   = s3_valid && ((s3_wbsel == WB_ALU) || (s3_wbsel == WB_PC4)) && !no_write_op;

    // In WAIT_LD the latched context is authoritative, whatever stage 3 shows.
    assign cur_ctx = (state_q == WAIT_LD) ? ctx_q
                                          : '{rd: s3_inst[11:7], funct3: s3_inst[14:12], off: s3_alu[1:0]};

    wb_stage_load_align #(.XLEN(XLEN)) u_align (
        .word   (dmem_rdata),
        .off    (cur_ctx.off),
        .funct3 (cur_ctx.funct3),
        .value  (aligned)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        we_d    = 1'b0;
        retire  = 1'b0;
        waddr_d = cur_ctx.rd;
        wdata_d = aligned;
        case (state_q)
            IDLE: begin
                if (is_load) begin
                    if (dmem_rvalid) begin
                        we_d   = (cur_ctx.rd != 5'd0);
                        retire = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT_LD;
                    end
                end else if (is_direct) begin
                    we_d    = (cur_ctx.rd != 5'd0);
                    wdata_d = (s3_wbsel == WB_PC4) ? s3_pc4 : s3_alu;
                    retire  = 1'b1;
                end else if (s3_valid) begin
                    retire = 1'b1;
                end
            end
            WAIT_LD: begin
                if (dmem_rvalid) begin
                    we_d    = (cur_ctx.rd != 5'd0);
                    retire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must release the upstream pipeline immediately, not at the next edge.
    assign wb_stall = stall && rst_n;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ctx_q    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state_q <= state_d;
            rf_we   <= we_d;
            if (we_d) begin
                rf_waddr <= waddr_d;
                rf_wdata <= wdata_d;
            end
            if (state_q == IDLE && state_d == WAIT_LD)
                ctx_q <= cur_ctx;
        end
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired <= '0;
            perf_ldwait  <= '0;
        end else begin
            if (retire)
                perf_retired <= perf_retired + 1'b1;
            if (state_q == WAIT_LD)
                perf_ldwait <= perf_ldwait + 1'b1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule
